programmable_frequency_divider: RTL and testbench

Runtime-programmable successor to the fixed divide-by-100 block. It divides in_clock by a loadable divisor N and produces a registered ~50% duty out_clock plus a one-cycle out_tick per output period. It supports pause/resume and clear, and applies new divisors glitch-free at period boundaries. It feeds the oven's seconds/timer logic.

---
 rtl/programmable_frequency_divider_pkg.sv | 21 ++
 rtl/programmable_frequency_divider_shadow.sv | 68 ++++++
 rtl/programmable_frequency_divider.sv | 168 ++++++++++++++++
 tb/tb_programmable_frequency_divider.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/programmable_frequency_divider_pkg.sv
// Shared types and helpers for the programmable frequency divider.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   state_t   - divider run state (STOPPED / RUNNING / PAUSED)
//   high_len  - length of the high phase of out_clock for divisor N
package freq_div_pkg;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } state_t;

  // High phase is ceil(N/2), so odd divisors get the extra cycle high.
  function automatic int unsigned high_len(input int unsigned n);
    return n - (n / 2);
  endfunction

endpackage

// File: rtl/programmable_frequency_divider_shadow.sv
// Divisor shadow register: validates loads, holds pending and active divisor.
// Latency: active divisor updates on the load edge (apply_now) or on the swap edge; error pulse one cycle after load.
// Backpressure: none; a newer valid load overwrites any pending one.
//
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_load           load request (caller masks it while a clear is in progress)
//   i_divisor        requested divisor
//   i_apply_now      divider is stopped: a valid load becomes active at once
//   i_swap           period boundary or clear: promote pending (or same-edge load)
//   o_active         divisor currently used by the counter
//   o_pending        a validated divisor is waiting for the next boundary
//   o_load_err       one-cycle pulse after a rejected (N<2) load
module divisor_shadow_reg #(
  parameter int CNT_WIDTH   = 8,
  parameter int DEFAULT_DIV = 100
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_load,
  input  logic [CNT_WIDTH-1:0] i_divisor,
  input  logic                 i_apply_now,
  input  logic                 i_swap,
  output logic [CNT_WIDTH-1:0] o_active,
  output logic                 o_pending,
  output logic                 o_load_err
);

  logic [CNT_WIDTH-1:0] r_active;
  logic [CNT_WIDTH-1:0] r_shadow;
  logic                 r_pending;
  logic                 r_load_err;
  logic                 w_valid;

  assign w_valid = i_load && (i_divisor >= CNT_WIDTH'(2));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active   <= CNT_WIDTH'(DEFAULT_DIV);
      r_shadow   <= '0;
      r_pending  <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= i_load && !w_valid;
      if (i_swap) begin
        // A load landing exactly on the boundary wins over the older pending value.
        if (w_valid) begin
          r_active <= i_divisor;
        end else if (r_pending) begin
          r_active <= r_shadow;
        end
        r_pending <= 1'b0;
      end else if (w_valid) begin
        if (i_apply_now) begin
          r_active <= i_divisor;
        end else begin
          r_shadow  <= i_divisor;
          r_pending <= 1'b1;
        end
      end
    end
  end

  assign o_active   = r_active;
  assign o_pending  = r_pending;
  assign o_load_err = r_load_err;

endmodule

// File: rtl/programmable_frequency_divider.sv
// Runtime-programmable clock divider: ~50% duty out_clock, one tick per period, pause/resume/clear.
// Latency: out_clock/out_count registered (1 cycle from enable); out_tick combinational from count.
// Backpressure: none; new divisors are deferred to the next period boundary instead of stalling.
//
// Optional feature macro: FREQ_DIV_PERIOD_COUNT_EN adds out_periods (completed-period counter).
//
// Ports:
//   in_clock, in_reset_n  clock (rising edge), async active-low reset
//   in_enable             run (1) / pause (0)
//   in_clear              synchronous return to STOPPED, promotes any pending divisor
//   in_load, in_divisor   one-cycle divisor load request
//   out_clock             divided clock, high for counts 0..ceil(N/2)-1
//   out_tick              high while running at count N-1
//   out_count             current phase count
//   out_pending           a loaded divisor waits for the next boundary
//   out_load_err          one-cycle pulse for a rejected load
//   out_periods           (optional) completed periods, modulo 2^PERIOD_CNT_WIDTH
module programmable_frequency_divider
  import freq_div_pkg::*;
#(
  parameter int CNT_WIDTH        = 8,
  parameter int DEFAULT_DIV      = 100,
  parameter int PERIOD_CNT_WIDTH = 16
) (
  input  logic                        in_clock,
  input  logic                        in_reset_n,
  input  logic                        in_enable,
  input  logic                        in_clear,
  input  logic                        in_load,
  input  logic [CNT_WIDTH-1:0]        in_divisor,
  output logic                        out_clock,
  output logic                        out_tick,
  output logic [CNT_WIDTH-1:0]        out_count,
  output logic                        out_pending,
  output logic                        out_load_err
`ifdef FREQ_DIV_PERIOD_COUNT_EN
  ,
  output logic [PERIOD_CNT_WIDTH-1:0] out_periods
`endif
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] w_count_nxt;
  logic [CNT_WIDTH-1:0] w_active;
  logic                 r_clock;
  logic                 w_clock_nxt;
  logic                 w_last;
  logic                 w_wrap;
  logic                 w_load;
  logic                 w_swap;

  assign w_last = (r_count == (w_active - CNT_ONE));
  // Wrap edge: the only point (besides clear) where the active divisor may change while running.
  assign w_wrap = !in_clear && (r_state == RUNNING) && in_enable && w_last;
  assign w_load = in_load && !in_clear;
  assign w_swap = w_wrap || in_clear;

  divisor_shadow_reg #(
    .CNT_WIDTH   (CNT_WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_shadow (
    .i_clk       (in_clock),
    .i_rst_n     (in_reset_n),
    .i_load      (w_load),
    .i_divisor   (in_divisor),
    .i_apply_now (r_state == STOPPED),
    .i_swap      (w_swap),
    .o_active    (w_active),
    .o_pending   (out_pending),
    .o_load_err  (out_load_err)
  );

  // State register
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_state <= STOPPED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (in_clear) begin
      w_state_nxt = STOPPED;
    end else begin
      case (r_state)
        STOPPED: w_state_nxt = in_enable ? RUNNING : STOPPED;
        RUNNING: w_state_nxt = in_enable ? RUNNING : PAUSED;
        PAUSED:  w_state_nxt = in_enable ? RUNNING : PAUSED;
        default: w_state_nxt = STOPPED;
      endcase
    end
  end

  // Output / datapath logic
  always_comb begin
    w_count_nxt = r_count;
    w_clock_nxt = r_clock;
    out_tick    = (r_state == RUNNING) && w_last;
    if (in_clear) begin
      w_count_nxt = '0;
      w_clock_nxt = 1'b0;
    end else begin
      case (r_state)
        STOPPED: begin
          w_count_nxt = '0;
          w_clock_nxt = in_enable;
        end
        RUNNING: begin
          if (in_enable) begin
            w_count_nxt = w_last ? '0 : (r_count + CNT_ONE);
            // Count 0 is always in the high phase, so a divisor swapped in at
            // the wrap cannot affect this compare on that edge.
            w_clock_nxt = (32'(w_count_nxt) < high_len(32'(w_active)));
          end
        end
        // Resuming re-enters RUNNING at the held count; counting continues next edge.
        PAUSED: begin
          w_count_nxt = r_count;
          w_clock_nxt = r_clock;
        end
        default: begin
          w_count_nxt = '0;
          w_clock_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_count <= '0;
      r_clock <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_clock <= w_clock_nxt;
    end
  end

  assign out_clock = r_clock;
  assign out_count = r_count;

`ifdef FREQ_DIV_PERIOD_COUNT_EN
  logic [PERIOD_CNT_WIDTH-1:0] r_periods;

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_periods <= '0;
    end else if (in_clear) begin
      r_periods <= '0;
    end else if (w_wrap) begin
      r_periods <= r_periods + PERIOD_CNT_WIDTH'(1);
    end
  end

  assign out_periods = r_periods;
`else
  logic w_unused_period_cnt_width;
  assign w_unused_period_cnt_width = ^PERIOD_CNT_WIDTH;
`endif

endmodule

// File: tb/tb_programmable_frequency_divider.sv
module tb_programmable_frequency_divider;

  logic        clk;
  logic        in_reset_n;
  logic        in_enable;
  logic        in_clear;
  logic        in_load;
  logic [7:0]  in_divisor;
  logic        out_clock;
  logic        out_tick;
  logic [7:0]  out_count;
  logic        out_pending;
  logic        out_load_err;
`ifdef FREQ_DIV_PERIOD_COUNT_EN
  logic [15:0] out_periods;
`endif

  programmable_frequency_divider #(
    .CNT_WIDTH        (8),
    .DEFAULT_DIV      (100),
    .PERIOD_CNT_WIDTH (16)
  ) dut (
    .in_clock     (clk),
    .in_reset_n   (in_reset_n),
    .in_enable    (in_enable),
    .in_clear     (in_clear),
    .in_load      (in_load),
    .in_divisor   (in_divisor),
    .out_clock    (out_clock),
    .out_tick     (out_tick),
    .out_count    (out_count),
    .out_pending  (out_pending),
    .out_load_err (out_load_err)
`ifdef FREQ_DIV_PERIOD_COUNT_EN
    ,
    .out_periods  (out_periods)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural reference: mode 0=stopped 1=running 2=paused
  int m_mode, m_cnt, m_n, m_pend_n, m_per;
  bit m_pend, m_err;

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_n = 100; m_pend_n = 0; m_per = 0; m_pend = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit en, input bit clr, input bit ld, input int div);
    bit ok;
    bit wrap;
    int prev;
    if (clr) begin
      if (m_pend) m_n = m_pend_n;
      m_pend = 0; m_mode = 0; m_cnt = 0; m_per = 0; m_err = 0;
      return;
    end
    ok    = ld && (div >= 2);
    m_err = ld && !ok;
    prev  = m_mode;
    wrap  = (prev == 1) && en && (m_cnt == m_n - 1);
    if (prev == 0) begin
      if (ok) m_n = div;
      if (en) begin m_mode = 1; m_cnt = 0; end
    end else if (prev == 1) begin
      if (!en) m_mode = 2;
      else if (wrap) begin
        m_cnt = 0;
        m_per = (m_per + 1) % 65536;
        if (ok) m_n = div;
        else if (m_pend) m_n = m_pend_n;
        m_pend = 0;
      end else m_cnt = m_cnt + 1;
    end else begin
      if (en) m_mode = 1;
    end
    if (ok && prev != 0 && !wrap) begin
      m_pend = 1; m_pend_n = div;
    end
  endtask

  task automatic check_model(input string tag);
    int exp_clk;
    exp_clk = (m_mode != 0 && m_cnt < (m_n - m_n / 2)) ? 1 : 0;
    cmp({tag, ".count"},   int'(out_count),    m_cnt);
    cmp({tag, ".clock"},   int'(out_clock),    exp_clk);
    cmp({tag, ".tick"},    int'(out_tick),     (m_mode == 1 && m_cnt == m_n - 1) ? 1 : 0);
    cmp({tag, ".pending"}, int'(out_pending),  int'(m_pend));
    cmp({tag, ".load_err"},int'(out_load_err), int'(m_err));
`ifdef FREQ_DIV_PERIOD_COUNT_EN
    cmp({tag, ".periods"}, int'(out_periods),  m_per);
`endif
  endtask

  task automatic step(input bit en, input bit clr, input bit ld, input int div, input string tag);
    @(negedge clk);
    in_enable  = en;
    in_clear   = clr;
    in_load    = ld;
    in_divisor = 8'(div);
    @(posedge clk);
    #1;
    model_edge(en, clr, ld, div);
    check_model(tag);
  endtask

  typedef struct {
    bit   en, clr, ld;
    int   div;
    int   cnt;
    bit   ck, tk, pd, er;
  } vec_t;

  vec_t tbl[26];

  initial begin
    int highs;
    in_reset_n = 1'b0; in_enable = 1'b0; in_clear = 1'b0; in_load = 1'b0; in_divisor = '0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    cmp("rst.clock", int'(out_clock), 0);
    cmp("rst.tick", int'(out_tick), 0);
    cmp("rst.count", int'(out_count), 0);
    cmp("rst.pending", int'(out_pending), 0);
    cmp("rst.load_err", int'(out_load_err), 0);
    @(negedge clk);
    in_reset_n = 1'b1;

    // Default divide-by-100 for 300 cycles
    highs = 0;
    for (int k = 0; k < 300; k++) begin
      step(1, 0, 0, 0, "div100");
      cmp("div100.count_dir", int'(out_count), k % 100);
      cmp("div100.tick_dir", int'(out_tick), (k % 100 == 99) ? 1 : 0);
      if (k < 100 && out_clock) highs++;
    end
    cmp("div100.high_cycles", highs, 50);

    // Load N=10 mid-period at count 30
    for (int k = 0; k < 31; k++) step(1, 0, 0, 0, "to30");
    cmp("to30.count", int'(out_count), 30);
    step(1, 0, 1, 10, "ld10");
    cmp("ld10.pending", int'(out_pending), 1);
    for (int i = 1; i <= 69; i++) begin
      step(1, 0, 0, 0, "finish100");
      if (i == 68) cmp("finish100.tick", int'(out_tick), 1);
      if (i == 69) begin
        cmp("finish100.wrap_count", int'(out_count), 0);
        cmp("finish100.pending_drop", int'(out_pending), 0);
      end
    end
    for (int i = 1; i <= 20; i++) begin
      step(1, 0, 0, 0, "div10");
      cmp("div10.count_dir", int'(out_count), i % 10);
      cmp("div10.clock_dir", int'(out_clock), (i % 10 < 5) ? 1 : 0);
    end

    // Rejected loads
    step(1, 0, 1, 1, "ld1");
    cmp("ld1.err", int'(out_load_err), 1);
    step(1, 0, 1, 0, "ld0");
    cmp("ld0.err", int'(out_load_err), 1);
    cmp("ld0.pending", int'(out_pending), 0);
    step(1, 0, 0, 0, "err_clear");
    cmp("err_clear.err", int'(out_load_err), 0);
    step(0, 1, 0, 0, "clear");

    // Table: N=5 pattern, errors, pause with pending, wrap-edge load, clear
    tbl[0]  = '{0,0,1,5, 0,0,0,0,0};
    tbl[1]  = '{1,0,0,0, 0,1,0,0,0};
    tbl[2]  = '{1,0,0,0, 1,1,0,0,0};
    tbl[3]  = '{1,0,0,0, 2,1,0,0,0};
    tbl[4]  = '{1,0,0,0, 3,0,0,0,0};
    tbl[5]  = '{1,0,0,0, 4,0,1,0,0};
    tbl[6]  = '{1,0,0,0, 0,1,0,0,0};
    tbl[7]  = '{1,0,1,1, 1,1,0,0,1};
    tbl[8]  = '{1,0,1,0, 2,1,0,0,1};
    tbl[9]  = '{1,0,0,0, 3,0,0,0,0};
    tbl[10] = '{0,0,0,0, 3,0,0,0,0};
    tbl[11] = '{0,0,1,3, 3,0,0,1,0};
    tbl[12] = '{1,0,0,0, 3,0,0,1,0};
    tbl[13] = '{1,0,0,0, 4,0,1,1,0};
    tbl[14] = '{1,0,0,0, 0,1,0,0,0};
    tbl[15] = '{1,0,0,0, 1,1,0,0,0};
    tbl[16] = '{1,0,0,0, 2,0,1,0,0};
    tbl[17] = '{1,0,0,0, 0,1,0,0,0};
    tbl[18] = '{1,0,0,0, 1,1,0,0,0};
    tbl[19] = '{1,0,0,0, 2,0,1,0,0};
    tbl[20] = '{1,0,1,4, 0,1,0,0,0};
    tbl[21] = '{1,0,0,0, 1,1,0,0,0};
    tbl[22] = '{1,0,0,0, 2,0,0,0,0};
    tbl[23] = '{1,0,0,0, 3,0,1,0,0};
    tbl[24] = '{1,1,0,0, 0,0,0,0,0};
    tbl[25] = '{0,0,0,0, 0,0,0,0,0};
    for (int r = 0; r < 26; r++) begin
      step(tbl[r].en, tbl[r].clr, tbl[r].ld, tbl[r].div, "tbl");
      cmp($sformatf("tbl%0d.count", r), int'(out_count), tbl[r].cnt);
      cmp($sformatf("tbl%0d.clock", r), int'(out_clock), int'(tbl[r].ck));
      cmp($sformatf("tbl%0d.tick", r), int'(out_tick), int'(tbl[r].tk));
      cmp($sformatf("tbl%0d.pending", r), int'(out_pending), int'(tbl[r].pd));
      cmp($sformatf("tbl%0d.err", r), int'(out_load_err), int'(tbl[r].er));
    end

    // Pause at count 40 for 20 cycles, resume, then clear
    step(1, 0, 1, 100, "p_start");
    for (int k = 0; k < 40; k++) step(1, 0, 0, 0, "p_run");
    cmp("pause.count40", int'(out_count), 40);
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 0, 0, "paused");
      cmp("paused.count", int'(out_count), 40);
      cmp("paused.clock", int'(out_clock), 1);
      cmp("paused.tick", int'(out_tick), 0);
    end
    step(1, 0, 0, 0, "resume");
    cmp("resume.count", int'(out_count), 40);
    for (int i = 1; i <= 60; i++) begin
      step(1, 0, 0, 0, "resumed");
      if (i == 59) cmp("resumed.tick", int'(out_tick), 1);
      if (i == 60) cmp("resumed.wrap", int'(out_count), 0);
    end
    step(1, 1, 0, 0, "clr2");
    cmp("clr2.count", int'(out_count), 0);
    cmp("clr2.clock", int'(out_clock), 0);

    // Three wraps at N=3, then async reset in the high phase
    step(1, 0, 1, 3, "n3_start");
    for (int k = 0; k < 9; k++) step(1, 0, 0, 0, "n3");
`ifdef FREQ_DIV_PERIOD_COUNT_EN
    cmp("periods.three", int'(out_periods), 3);
`endif
    step(1, 0, 0, 0, "n3_high");
    cmp("prereset.clock", int'(out_clock), 1);
    #2;
    in_reset_n = 1'b0;
    #1;
    model_reset();
    cmp("async_rst.clock", int'(out_clock), 0);
    cmp("async_rst.count", int'(out_count), 0);
    cmp("async_rst.tick", int'(out_tick), 0);
`ifdef FREQ_DIV_PERIOD_COUNT_EN
    cmp("async_rst.periods", int'(out_periods), 0);
`endif
    @(negedge clk);
    in_enable = 1'b0;
    in_reset_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      step(1, 0, 0, 0, "post_rst");
      if (k == 99) cmp("post_rst.tick99", int'(out_tick), 1);
    end

    // Randomized traffic against the reference model
    for (int k = 0; k < 3000; k++) begin
      bit en, clr, ld;
      int div;
      en  = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 63) == 0);
      ld  = ($urandom_range(0, 7) == 0);
      div = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 9));
      step(en, clr, ld, div, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
